// File: rtl/spiflash_pkg.sv
// Shared types and constants for the SPI flash READ initiator.
package spiflash_pkg;

  localparam logic [7:0]  SPI_CMD_READ = 8'h03;
  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BIT_CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    GAP
  } state_e;

  // Opcode and address as they go out on io0, MSB first.
  typedef struct packed {
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
  } spi_cmd_t;

  // Return w with byte lane `lane` replaced by b.
  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        lane,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spiflash_clkgen.sv
// SPI clock generator: CLK_HALF cycles low, CLK_HALF high; the rise can be stalled.
module spiflash_clkgen #(
  parameter int unsigned CLK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic stall_i,
  output logic spiclk_o,
  output logic rise_en_c,
  output logic fall_en_c
);

  localparam int unsigned     PH_W    = $clog2(CLK_HALF) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_HALF - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            spiclk_q, spiclk_d;
  logic            at_end;

  // Strobes mark the ap_clk edge on which spiclk will toggle.
  always_comb begin
    phase_d   = phase_q;
    spiclk_d  = spiclk_q;
    at_end    = (phase_q == PH_LAST);
    rise_en_c = en_i && !spiclk_q && at_end && !stall_i;
    fall_en_c = en_i && spiclk_q && at_end;
    if (!en_i) begin
      phase_d  = '0;
      spiclk_d = 1'b0;
    end else if (rise_en_c || fall_en_c) begin
      phase_d  = '0;
      spiclk_d = !spiclk_q;
    end else if (!at_end) begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      spiclk_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      spiclk_q <= spiclk_d;
    end
  end

  assign spiclk_o = spiclk_q;

endmodule

// File: rtl/spiflash_reader.sv
// SPI flash READ (0x03) initiator returning little-endian 32-bit words in bursts.
module spiflash_reader
  import spiflash_pkg::*;
#(
  parameter int unsigned CLK_HALF = 2,
  parameter int unsigned CSB_GAP  = 4,
  parameter int unsigned LEN_W    = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              csb,
  output logic              spiclk,
  output logic              io0,
  input  logic              io1
);

  localparam int unsigned GAP_W = $clog2(CSB_GAP) + 1;

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      tx_q, tx_d;
  logic [6:0]             rx_q, rx_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]       words_q, words_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   csb_q, csb_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_last_q, rd_last_d;
  logic [WORD_W-1:0]      rd_data_q, rd_data_d;

  logic                   run_c, stall_c, rise_en_c, fall_en_c;
  logic [7:0]             byte_c;
  spi_cmd_t               cmd_c;

  assign run_c   = (state_q == CMD) || (state_q == DATA) || ((state_q == GAP) && !csb_q);
  // Only the edge that would complete a word waits for the output register.
  assign stall_c = (state_q == DATA) && (bit_q == 5'd31) && rd_valid_q && !rd_ready;
  assign byte_c  = {rx_q, io1};

  spiflash_clkgen #(
    .CLK_HALF (CLK_HALF)
  ) u_clkgen (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en_i      (run_c),
    .stall_i   (stall_c),
    .spiclk_o  (spiclk),
    .rise_en_c (rise_en_c),
    .fall_en_c (fall_en_c)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    word_d      = word_q;
    bit_d       = bit_q;
    words_d     = words_q;
    gap_d       = gap_q;
    csb_d       = csb_q;
    busy_d      = busy_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    cmd_c.op    = SPI_CMD_READ;
    cmd_c.addr  = cmd_addr;

    if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-length request completes the handshake and is discarded.
        if (cmd_valid && cmd_ready_q && (cmd_len != '0)) begin
          tx_d    = cmd_c;
          words_d = cmd_len;
          bit_d   = '0;
          csb_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        // Zero fill leaves io0 low once all 32 command bits are out.
        if (fall_en_c) begin
          tx_d  = {tx_q[WORD_W-2:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) state_d = DATA;
        end
      end
      DATA: begin
        if (rise_en_c) begin
          rx_d  = byte_c[6:0];
          bit_d = bit_q + 5'd1;
          if (bit_q[2:0] == 3'd7) word_d = put_lane(word_q, bit_q[4:3], byte_c);
          if (bit_q == 5'd31) begin
            rd_data_d  = word_d;
            rd_valid_d = 1'b1;
            rd_last_d  = (words_q == LEN_W'(1));
            words_d    = words_q - LEN_W'(1);
            if (words_q == LEN_W'(1)) state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!csb_q) begin
          if (fall_en_c) begin
            csb_d = 1'b1;
            gap_d = '0;
          end
        end else if (gap_q == GAP_W'(CSB_GAP - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      word_q      <= '0;
      bit_q       <= '0;
      words_q     <= '0;
      gap_q       <= '0;
      csb_q       <= 1'b1;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      words_q     <= words_d;
      gap_q       <= gap_d;
      csb_q       <= csb_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign csb       = csb_q;
  assign io0       = tx_q[WORD_W-1];

endmodule

// File: tb/tb_spiflash_reader.sv
// Directed bench for spiflash_reader with a mode-0 flash model, byte[a] = a[7:0] ^ 8'hA5.
module tb_spiflash_reader;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        csb;
  logic        spiclk;
  logic        io0;
  logic        io1 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rise   = 0;

  int          fcnt = 0;
  logic [31:0] fcmd = '0;

  spiflash_reader #(
    .CLK_HALF (2),
    .CSB_GAP  (4),
    .LEN_W    (8)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .csb       (csb),
    .spiclk    (spiclk),
    .io0       (io0),
    .io1       (io1)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;
  always @(posedge spiclk) n_rise <= n_rise + 1;

  // Flash model: capture 32 command bits, then shift data out after each falling edge.
  always @(posedge spiclk or posedge csb) begin
    if (csb) fcnt = 0;
    else begin
      if (fcnt < 32) fcmd = {fcmd[30:0], io0};
      fcnt = fcnt + 1;
    end
  end

  always @(negedge spiclk) begin
    logic [23:0] a;
    logic [7:0]  b;
    int          idx;
    if (!csb && fcnt >= 32) begin
      idx = fcnt - 32;
      a   = fcmd[23:0] + 24'(idx / 8);
      b   = a[7:0] ^ 8'hA5;
      io1 = b[7 - (idx % 8)];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [23:0] addr, input logic [7:0] len,
                        output int c0);
    bit got;
    got = 1'b0;
    c0  = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge ap_clk);
      if (cmd_ready) got = 1'b1;
    end
    check_eq({tag, "_cmd_ready"}, 32'(got), 32'd1);
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    c0        = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic get_word(input string tag, output logic [31:0] d, output logic l, output int c);
    bit got;
    got = 1'b0;
    d   = '0;
    l   = 1'b0;
    c   = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge ap_clk);
      if (rd_valid) begin
        got = 1'b1;
        d   = rd_data;
        l   = rd_last;
        c   = cyc;
      end
    end
    check_eq({tag, "_rd_valid_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge ap_clk);
      if (!busy && csb) done = 1'b1;
    end
    check_eq({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  logic [31:0] exp_w [3];
  logic [31:0] d, d_hold;
  logic        l;
  int          c0, c1, r0, cnt, viol, unstable;
  bit          seen_busy, seen_csb_low, seen_rdv, got;

  initial begin
    ap_rst_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rd_ready  = 1'b1;

    // Reset values
    repeat (3) @(negedge ap_clk);
    check_eq("rst_csb",       32'(csb),       32'd1);
    check_eq("rst_spiclk",    32'(spiclk),    32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rd_valid",  32'(rd_valid),  32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle_csb",       32'(csb),       32'd1);
    check_eq("idle_spiclk",    32'(spiclk),    32'd0);
    check_eq("idle_io0",       32'(io0),       32'd0);

    // Single aligned word
    r0 = n_rise;
    do_cmd("t1", 24'h000010, 8'd1, c0);
    get_word("t1", d, l, c1);
    check_eq("t1_data", d, 32'hB6B7B4B5);
    check_eq("t1_last", 32'(l), 32'd1);
    check_eq("t1_latency_ok", 32'((c1 - c0) >= 254 && (c1 - c0) <= 258), 32'd1);
    check_eq("t1_io0_cmd", fcmd, 32'h03000010);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge ap_clk);
      if (csb) got = 1'b1;
    end
    check_eq("t1_csb_rise", 32'(got), 32'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (!csb) viol++;
      cnt++;
      @(negedge ap_clk);
    end
    check_eq("t1_csb_gap_ge4", 32'(cnt >= 4), 32'd1);
    check_eq("t1_spiclk_rises", 32'(n_rise - r0), 32'd64);

    // Unaligned three-word burst
    exp_w[0] = 32'hA3A0A1A6;
    exp_w[1] = 32'hAFACADA2;
    exp_w[2] = 32'hABA8A9AE;
    do_cmd("t2", 24'h000003, 8'd3, c0);
    for (int w = 0; w < 3; w++) begin
      get_word($sformatf("t2_w%0d", w), d, l, c1);
      check_eq($sformatf("t2_data%0d", w), d, exp_w[w]);
      check_eq($sformatf("t2_last%0d", w), 32'(l), 32'(w == 2));
    end
    check_eq("t2_io0_cmd", fcmd, 32'h03000003);
    wait_idle("t2");

    // Backpressure: hold rd_ready low until the second word's last edge is stalled
    rd_ready = 1'b0;
    do_cmd("t3", 24'h000020, 8'd2, c0);
    get_word("t3_w0", d, l, c1);
    check_eq("t3_data0", d, 32'h86878485);
    check_eq("t3_last0", 32'(l), 32'd0);
    repeat (140) @(negedge ap_clk);
    r0       = n_rise;
    d_hold   = rd_data;
    viol     = 0;
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      if (spiclk) viol++;
      if (!rd_valid || rd_data !== d_hold || rd_last) unstable++;
    end
    check_eq("t3_stall_spiclk_high", 32'(viol), 32'd0);
    check_eq("t3_stall_rises", 32'(n_rise - r0), 32'd0);
    check_eq("t3_stall_unstable", 32'(unstable), 32'd0);
    check_eq("t3_hold_data", d_hold, 32'h86878485);
    rd_ready = 1'b1;
    get_word("t3_w1", d, l, c1);
    check_eq("t3_data1", d, 32'h82838081);
    check_eq("t3_last1", 32'(l), 32'd1);
    wait_idle("t3");

    // Device address wrap
    do_cmd("t4", 24'hFFFFFE, 8'd1, c0);
    get_word("t4", d, l, c1);
    check_eq("t4_data", d, 32'hA4A55A5B);
    check_eq("t4_last", 32'(l), 32'd1);
    check_eq("t4_io0_cmd", fcmd, 32'h03FFFFFE);
    wait_idle("t4");

    // Reset mid-DATA, then a zero-length request
    do_cmd("t5", 24'h000000, 8'd4, c0);
    repeat (200) @(negedge ap_clk);
    check_eq("t5_pre_csb_low", 32'(csb), 32'd0);
    ap_rst_n = 1'b0;
    #1;
    check_eq("t5_rst_csb",      32'(csb),      32'd1);
    check_eq("t5_rst_spiclk",   32'(spiclk),   32'd0);
    check_eq("t5_rst_busy",     32'(busy),     32'd0);
    check_eq("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen_busy    = 1'b0;
    seen_csb_low = 1'b0;
    seen_rdv     = 1'b0;
    do_cmd("t6", 24'h000040, 8'd0, c0);
    for (int i = 0; i < 60; i++) begin
      @(negedge ap_clk);
      if (busy) seen_busy = 1'b1;
      if (!csb) seen_csb_low = 1'b1;
      if (rd_valid) seen_rdv = 1'b1;
    end
    check_eq("t6_busy_seen",    32'(seen_busy),    32'd0);
    check_eq("t6_csb_low_seen", 32'(seen_csb_low), 32'd0);
    check_eq("t6_rd_valid_seen", 32'(seen_rdv),    32'd0);
    check_eq("t6_cmd_ready",    32'(cmd_ready),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
